// File: rtl/draw_pkg.sv
// Shared types and constants for the VGA draw path.
package draw_pkg;

    typedef logic [7:0] rgb_t;

    localparam rgb_t TRANSPARENT_COLOR = 8'hFF;
    localparam int   DEFAULT_NUM_REQ   = 4;

endpackage

// File: rtl/draw_priority_arbiter_priority_encoder.sv
// Combinational lowest-index-first encoder with a multi-hit flag (two or more
// requests set). Shared with the game-logic collision handler.
module priority_encoder #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o,
    output logic          multi_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid_o = |req_i;
        idx_o   = {IW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IW'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

    // A second set bit after any earlier one means popcount >= 2.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        multi_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                multi_o = multi_o | seen;
                seen    = 1'b1;
            end else begin
                seen    = seen;
            end
        end
    end

endmodule

// File: rtl/draw_priority_arbiter.sv
// Fixed-priority pixel compositor with frame-aligned enable mask and per-frame
// collision reporting; collision logic is built only with DRAW_ARB_COLLISION_EN.
module draw_priority_arbiter
    import draw_pkg::*;
#(
    parameter int   NUM_REQ     = DEFAULT_NUM_REQ,
    parameter rgb_t TRANSPARENT = TRANSPARENT_COLOR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startOfFrame,
    input  logic [NUM_REQ-1:0]         drawingRequest,
    input  logic [NUM_REQ*8-1:0]       objRGB,
    input  logic [7:0]                 BG_RGB,
    input  logic                       cfgWrEn,
    input  logic [NUM_REQ-1:0]         cfgMask,
    output logic [7:0]                 RGBOut,
    output logic                       grantValid,
    output logic [$clog2(NUM_REQ)-1:0] grantIdx,
    output logic [NUM_REQ-1:0]         collisionMask,
    output logic                       collisionPulse
);

    localparam int IDX_W = $clog2(NUM_REQ);

    rgb_t               obj_rgb_s [NUM_REQ];
    logic [NUM_REQ-1:0] opaque_s;
    logic [NUM_REQ-1:0] eff_mask_s;
    logic [NUM_REQ-1:0] req_s;
    logic               win_valid_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               multi_hit_s;

    logic [NUM_REQ-1:0] pending_mask_q, pending_mask_d;
    logic [NUM_REQ-1:0] active_mask_q;
    rgb_t               rgb_q, rgb_d;
    logic               grant_valid_q;
    logic [IDX_W-1:0]   grant_idx_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign obj_rgb_s[g] = objRGB[8*g +: 8];
        assign opaque_s[g]  = (objRGB[8*g +: 8] != TRANSPARENT);
    end

    // The mask loaded at startOfFrame already applies to that same pixel.
    always_comb begin
        if (startOfFrame) begin
            if (cfgWrEn) begin
                eff_mask_s = cfgMask;
            end else begin
                eff_mask_s = pending_mask_q;
            end
        end else begin
            eff_mask_s = active_mask_q;
        end
    end

    assign req_s = drawingRequest & eff_mask_s & opaque_s;

    priority_encoder #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_enc (
        .req_i   (req_s),
        .valid_o (win_valid_s),
        .idx_o   (win_idx_s),
        .multi_o (multi_hit_s)
    );

    // Next-state for pending mask and the composited pixel.
    always_comb begin
        pending_mask_d = pending_mask_q;
        rgb_d          = BG_RGB;
        if (cfgWrEn) begin
            pending_mask_d = cfgMask;
        end else begin
            pending_mask_d = pending_mask_q;
        end
        if (win_valid_s) begin
            rgb_d = obj_rgb_s[win_idx_s];
        end else begin
            rgb_d = BG_RGB;
        end
    end

    // Pixel output and mask registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_mask_q <= {NUM_REQ{1'b1}};
            active_mask_q  <= {NUM_REQ{1'b1}};
            rgb_q          <= 8'h00;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= {IDX_W{1'b0}};
        end else begin
            pending_mask_q <= pending_mask_d;
            active_mask_q  <= eff_mask_s;
            rgb_q          <= rgb_d;
            grant_valid_q  <= win_valid_s;
            grant_idx_q    <= win_idx_s;
        end
    end

    assign RGBOut     = rgb_q;
    assign grantValid = grant_valid_q;
    assign grantIdx   = grant_idx_q;

`ifdef DRAW_ARB_COLLISION_EN
    logic [NUM_REQ-1:0] contrib_s;
    logic [NUM_REQ-1:0] accum_q, accum_d;
    logic [NUM_REQ-1:0] coll_mask_q;
    logic               coll_pulse_q;

    // The startOfFrame pixel opens the new frame's accumulator.
    always_comb begin
        if (multi_hit_s) begin
            contrib_s = req_s;
        end else begin
            contrib_s = {NUM_REQ{1'b0}};
        end
        if (startOfFrame) begin
            accum_d = contrib_s;
        end else begin
            accum_d = accum_q | contrib_s;
        end
    end

    // Collision accumulator and per-frame report.
    always_ff @(posedge clk) begin
        if (reset) begin
            accum_q      <= {NUM_REQ{1'b0}};
            coll_mask_q  <= {NUM_REQ{1'b0}};
            coll_pulse_q <= 1'b0;
        end else begin
            accum_q <= accum_d;
            if (startOfFrame) begin
                coll_mask_q  <= accum_q;
                coll_pulse_q <= |accum_q;
            end else begin
                coll_mask_q  <= coll_mask_q;
                coll_pulse_q <= 1'b0;
            end
        end
    end

    assign collisionMask  = coll_mask_q;
    assign collisionPulse = coll_pulse_q;
`else
    logic collision_unused_s;
    assign collision_unused_s = multi_hit_s;
    assign collisionMask      = {NUM_REQ{1'b0}};
    assign collisionPulse     = 1'b0;
`endif

endmodule

// File: tb/tb_draw_priority_arbiter.sv
// Directed bench for draw_priority_arbiter; collision expectations follow
// whether DRAW_ARB_COLLISION_EN is defined.
module tb_draw_priority_arbiter;

`ifdef DRAW_ARB_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic [3:0]  drawingRequest;
    logic [31:0] objRGB;
    logic [7:0]  BG_RGB;
    logic        cfgWrEn;
    logic [3:0]  cfgMask;
    logic [7:0]  RGBOut;
    logic        grantValid;
    logic [1:0]  grantIdx;
    logic [3:0]  collisionMask;
    logic        collisionPulse;

    int checks = 0;
    int errors = 0;

    draw_priority_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .drawingRequest (drawingRequest),
        .objRGB         (objRGB),
        .BG_RGB         (BG_RGB),
        .cfgWrEn        (cfgWrEn),
        .cfgMask        (cfgMask),
        .RGBOut         (RGBOut),
        .grantValid     (grantValid),
        .grantIdx       (grantIdx),
        .collisionMask  (collisionMask),
        .collisionPulse (collisionPulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [7:0] rgb, input logic gv, input logic [1:0] idx, input string tag);
        chk({tag, ".rgb"}, {24'd0, RGBOut}, {24'd0, rgb});
        chk({tag, ".gv"},  {31'd0, grantValid}, {31'd0, gv});
        chk({tag, ".idx"}, {30'd0, grantIdx}, {30'd0, idx});
    endtask

    task automatic coll(input logic [3:0] m, input logic p, input string tag);
        chk({tag, ".cmask"},  {28'd0, collisionMask}, {28'd0, (COLL ? m : 4'b0000)});
        chk({tag, ".cpulse"}, {31'd0, collisionPulse}, {31'd0, (COLL ? p : 1'b0)});
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; drawingRequest = 4'b0000;
        objRGB = 32'h0000_0000; BG_RGB = 8'h5C; cfgWrEn = 1'b0; cfgMask = 4'b0000;
        step; step;
        pix(8'h00, 1'b0, 2'd0, "reset");
        coll(4'b0000, 1'b0, "reset");

        reset = 1'b0;
        step;
        pix(8'h5C, 1'b0, 2'd0, "bg");

        startOfFrame = 1'b1;
        step;
        startOfFrame = 1'b0;
        coll(4'b0000, 1'b0, "sof0");

        drawingRequest = 4'b1010; objRGB = {8'hE0, 8'hAA, 8'h1C, 8'h33};
        step;
        pix(8'h1C, 1'b1, 2'd1, "r13");

        drawingRequest = 4'b1000;
        step;
        pix(8'hE0, 1'b1, 2'd3, "r3");

        drawingRequest = 4'b0000; startOfFrame = 1'b1;
        step;
        startOfFrame = 1'b0;
        pix(8'h5C, 1'b0, 2'd0, "sof1");
        coll(4'b1010, 1'b1, "sof1");
        step;
        coll(4'b1010, 1'b0, "hold1");

        drawingRequest = 4'b0001; objRGB = {8'hE0, 8'hAA, 8'h1C, 8'hFF};
        step;
        pix(8'h5C, 1'b0, 2'd0, "transp");
        drawingRequest = 4'b0011;
        step;
        pix(8'h1C, 1'b1, 2'd1, "transp1");

        objRGB = {8'hE0, 8'hAA, 8'h1C, 8'h33}; drawingRequest = 4'b0001;
        cfgWrEn = 1'b1; cfgMask = 4'b1110;
        step;
        cfgWrEn = 1'b0;
        pix(8'h33, 1'b1, 2'd0, "cfgmid");
        step;
        pix(8'h33, 1'b1, 2'd0, "cfgmid2");
        startOfFrame = 1'b1;
        step;
        startOfFrame = 1'b0;
        pix(8'h5C, 1'b0, 2'd0, "cfgsof");
        coll(4'b0000, 1'b0, "cfgsof");
        step;
        pix(8'h5C, 1'b0, 2'd0, "cfgafter");

        cfgWrEn = 1'b1; cfgMask = 4'b1111; startOfFrame = 1'b1;
        step;
        cfgWrEn = 1'b0;
        pix(8'h33, 1'b1, 2'd0, "cfgsame");

        drawingRequest = 4'b0011;
        step;
        pix(8'h33, 1'b1, 2'd0, "b2b0");
        coll(4'b0000, 1'b0, "b2b0");
        drawingRequest = 4'b0000;
        step;
        startOfFrame = 1'b0;
        coll(4'b0011, 1'b1, "b2b1");

        drawingRequest = 4'b0101;
        step;
        pix(8'h33, 1'b1, 2'd0, "r02");
        coll(4'b0011, 1'b0, "r02");
        reset = 1'b1;
        step;
        reset = 1'b0; drawingRequest = 4'b0000;
        pix(8'h00, 1'b0, 2'd0, "midrst");
        coll(4'b0000, 1'b0, "midrst");
        startOfFrame = 1'b1;
        step;
        startOfFrame = 1'b0;
        coll(4'b0000, 1'b0, "rstsof");
        step;
        coll(4'b0000, 1'b0, "rstsof2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/draw_priority_arbiter.md
# draw_priority_arbiter

Per-pixel compositor and controller for the VGA draw path. It arbitrates the drawing requests of the game objects (balls, cue, pockets) against the background RGB from the background drawer, using fixed priority, and registers the winning pixel colour. It also applies a per-requester enable mask that software updates only on frame boundaries, and accumulates per-frame object collisions for the game logic. It sits between the object/background drawers and the VGA output stage.

## Interface
- NUM_REQ, 4: number of object requesters; index 0 has the highest priority.
- TRANSPARENT, 8'hFF: object colour treated as "no draw" even when that object's request is high.
- clk  in  1: pixel clock.
- reset  in  1: synchronous, active-high reset.
- startOfFrame  in  1: one-cycle pulse at pixel (0,0), from the VGA sync block.
- drawingRequest  in  NUM_REQ: per-object request; bit i belongs to object i.
- objRGB  in  NUM_REQ*8: object colours; bits [8i+7:8i] belong to object i.
- BG_RGB  in  8: background colour.
- cfgWrEn  in  1: one-cycle strobe that writes cfgMask into the pending mask.
- cfgMask  in  NUM_REQ: requester enable mask, 1 = enabled.
- RGBOut  out  8: composited pixel colour.
- grantValid  out  1: an object won the current pixel.
- grantIdx  out  $clog2(NUM_REQ): index of the winning object; 0 when grantValid=0.
- collisionMask  out  NUM_REQ: objects involved in collisions during the previous frame.
- collisionPulse  out  1: one-cycle pulse when a frame with a non-empty collision mask completes.

## Operation
- Effective request: req_i = drawingRequest[i] & activeMask[i] & (objRGB_i != TRANSPARENT).
- Winner: the lowest i with req_i = 1. RGBOut <= objRGB_winner, grantValid <= 1, grantIdx <= i.
  - With no effective request: RGBOut <= BG_RGB, grantValid <= 0, grantIdx <= 0.
- Mask handling:
  - cfgWrEn loads pendingMask.
  - On startOfFrame, activeMask <= pendingMask, so the mask never changes mid-frame.
  - If cfgWrEn and startOfFrame occur in the same cycle, the new cfgMask goes straight to activeMask as well as pendingMask.
- Collision accumulation:
  - A pixel collides when popcount(req) >= 2. On such a pixel, accum |= req.
  - On startOfFrame: collisionMask <= accum (which excludes the current cycle), collisionPulse <= |accum, and accum <= the current cycle's contribution (req if it collides, else 0).
  - collisionMask holds its value until the next startOfFrame.
- Reset values:
  - RGBOut = 8'h00, grantValid = 0, grantIdx = 0, collisionMask = 0, collisionPulse = 0.
  - accum = 0, pendingMask = activeMask = all ones.

## Timing
- RGBOut, grantValid and grantIdx follow the inputs by exactly 1 clk. The sync block delays hsync/vsync by 1 clk to match.
- The activeMask change takes effect in the same cycle as the startOfFrame pulse: a pixel presented with startOfFrame is evaluated with the new mask.
- collisionPulse is high exactly 1 clk, in the cycle after startOfFrame.
- reset asserted mid-frame clears all state on the next edge. The first startOfFrame after reset reports collisionMask = 0 and produces no pulse.
- Back-to-back startOfFrame pulses (degenerate one-pixel frame) are legal. Each one closes a frame.

## Configuration
- DRAW_ARB_COLLISION_EN:
  - Defined: collision accumulation, collisionMask and collisionPulse function as specified.
  - Undefined: the accumulator is not built, and collisionMask and collisionPulse are tied to 0. Compositing and mask behaviour are unchanged.

## Structure
- Shared package draw_pkg:
  - typedef rgb_t (logic [7:0]).
  - constant TRANSPARENT_COLOR = 8'hFF.
  - constant DEFAULT_NUM_REQ = 4.
- Sub-module priority_encoder: a parameterised combinational encoder.
  - Input: req vector.
  - Outputs: valid, lowest set index, and a multi-hit flag (popcount >= 2).
  - It is reused by the game-logic collision handler.
- All registers live in draw_priority_arbiter.

## Test plan
- Reset, then BG_RGB=8'h5C with no requests -> after 1 clk RGBOut=8'h5C, grantValid=0, grantIdx=0.
- req[1] and req[3] high, objRGB1=8'h1C, objRGB3=8'hE0 -> RGBOut=8'h1C, grantIdx=1.
  - In the same frame a later pixel has only req[3] high -> RGBOut=8'hE0, grantIdx=3.
  - At the next startOfFrame -> collisionMask=4'b1010 and collisionPulse high exactly 1 clk.
- req[0] high with objRGB0=8'hFF -> object 0 is transparent; RGBOut=BG_RGB, grantValid=0.
- cfgWrEn with cfgMask=4'b1110 mid-frame, req[0] high -> object 0 is still drawn until startOfFrame, then BG_RGB is output from that cycle onward.
- Collisions in frame N, then reset asserted mid-frame N+1 -> all outputs 0. The next startOfFrame gives collisionMask=0 and no pulse.
- Build without DRAW_ARB_COLLISION_EN, repeat the second scenario -> RGBOut identical; collisionMask and collisionPulse stay 0.
